// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: amp*cos(angle) and amp*sin(angle) from a 0.1-degree angle,
// one micro-rotation per clock through a single shared engine with valid/ready on both sides.
module cordic_sincos #(
   parameter int WIDTH       = 16,
   parameter int ANGLE_WIDTH = 16,
   parameter int ITERATIONS  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ANGLE_WIDTH-1:0] angle_in,
   input  logic [WIDTH-1:0]       amp_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       cos_out,
   output logic [WIDTH-1:0]       sin_out,
   output logic                   range_err,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int XW = WIDTH + 4;
   localparam int ZW = 24;
   localparam int PW = WIDTH + 16;
   localparam logic signed [PW-1:0] K_SCALE = PW'(19899);
   localparam logic signed [XW-1:0] HALF    = XW'(2);
   localparam logic signed [XW-1:0] MAXP    = XW'(2 ** (WIDTH - 1) - 1);
   localparam logic signed [XW-1:0] MINP    = -MAXP;
   localparam logic [4:0]           LAST    = 5'(ITERATIONS - 1);

   typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

   state_t                  state_q, state_d;
   logic [4:0]              iter_q, iter_d;
   logic [ANGLE_WIDTH-1:0]  angle_q, angle_d;
   logic [WIDTH-1:0]        amp_q, amp_d;
   logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
   logic signed [ZW-1:0]    z_q, z_d;
   logic                    flag_q, flag_d;
   logic [WIDTH-1:0]        cos_q, cos_d, sin_q, sin_d;
   logic                    err_q, err_d;
   logic                    valid_q, valid_d;

   logic signed [PW-1:0]    amp_ext;
   logic signed [XW-1:0]    a_val, dx, dy;
   logic signed [ZW-1:0]    ang_ext, step;

   function automatic logic signed [ZW-1:0] atan_tab(input logic [4:0] idx);
      case (idx)
         5'd0:    return 24'sd115200;
         5'd1:    return 24'sd68007;
         5'd2:    return 24'sd35933;
         5'd3:    return 24'sd18240;
         5'd4:    return 24'sd9155;
         5'd5:    return 24'sd4582;
         5'd6:    return 24'sd2292;
         5'd7:    return 24'sd1146;
         5'd8:    return 24'sd573;
         5'd9:    return 24'sd286;
         5'd10:   return 24'sd143;
         5'd11:   return 24'sd72;
         5'd12:   return 24'sd36;
         5'd13:   return 24'sd18;
         5'd14:   return 24'sd9;
         5'd15:   return 24'sd4;
         default: return '0;
      endcase
   endfunction

   // Drop the 2 fraction bits with round-half-up, then clamp symmetrically.
   function automatic logic [WIDTH-1:0] sat_round(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] r;
      r = (v + HALF) >>> 2;
      if (r > MAXP)      return MAXP[WIDTH-1:0];
      else if (r < MINP) return MINP[WIDTH-1:0];
      else               return r[WIDTH-1:0];
   endfunction

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      angle_d = angle_q;
      amp_d   = amp_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      flag_d  = flag_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      err_d   = err_q;
      valid_d = valid_q;

      amp_ext = {{16{amp_q[WIDTH-1]}}, amp_q};
      a_val   = XW'((amp_ext * K_SCALE) >>> 13);
      ang_ext = {{(ZW-ANGLE_WIDTH){angle_q[ANGLE_WIDTH-1]}}, angle_q};
      dx      = x_q >>> iter_q;
      dy      = y_q >>> iter_q;
      step    = atan_tab(iter_q);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               angle_d = angle_in;
               amp_d   = amp_in;
               state_d = PREP;
            end
         end
         PREP: begin
            iter_d  = '0;
            flag_d  = 1'b0;
            state_d = ITER;
            if (ang_ext > 24'sd1800 || ang_ext < -24'sd1800) begin
               flag_d = 1'b1;
               x_d    = '0;
               y_d    = '0;
               z_d    = '0;
            end else if (ang_ext > 24'sd900) begin
               x_d = '0;
               y_d = a_val;
               z_d = (ang_ext - 24'sd900) <<< 8;
            end else if (ang_ext < -24'sd900) begin
               x_d = '0;
               y_d = -a_val;
               z_d = (ang_ext + 24'sd900) <<< 8;
            end else begin
               x_d = a_val;
               y_d = '0;
               z_d = ang_ext <<< 8;
            end
         end
         ITER: begin
            if (!z_q[ZW-1]) begin
               x_d = x_q - dy;
               y_d = y_q + dx;
               z_d = z_q - step;
            end else begin
               x_d = x_q + dy;
               y_d = y_q - dx;
               z_d = z_q + step;
            end
            iter_d = iter_q + 5'd1;
            if (iter_q == LAST) state_d = DONE;
         end
         DONE: begin
            // First DONE cycle registers the result; later cycles wait for the consumer.
            if (!valid_q) begin
               cos_d   = sat_round(x_q);
               sin_d   = sat_round(y_q);
               err_d   = flag_q;
               valid_d = 1'b1;
            end else if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         iter_q  <= '0;
         angle_q <= '0;
         amp_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         flag_q  <= 1'b0;
         cos_q   <= '0;
         sin_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         angle_q <= angle_d;
         amp_q   <= amp_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         flag_q  <= flag_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && rst_n;
   assign cos_out   = cos_q;
   assign sin_out   = sin_q;
   assign range_err = err_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: reset, angle sweep, full-scale, range errors,
// output stall, and reset during an in-flight operation.
module tb_cordic_sincos;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] angle_in;
   logic [15:0] amp_in;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] cos_out;
   logic [15:0] sin_out;
   logic        range_err;
   logic        out_valid;
   logic        out_ready;

   int total = 0;
   int bad   = 0;

   cordic_sincos #(.WIDTH(16), .ANGLE_WIDTH(16), .ITERATIONS(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .angle_in  (angle_in),
      .amp_in    (amp_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cos_out   (cos_out),
      .sin_out   (sin_out),
      .range_err (range_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Present an operation and return just after the accepting edge.
   task automatic start_op(input int ang, input int amp);
      int n;
      angle_in = 16'(ang);
      amp_in   = 16'(amp);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input int ang, input int amp, output int c, output int s,
                         output logic e, output int lat);
      start_op(ang, amp);
      wait_valid(lat);
      c = int'($signed(cos_out));
      s = int'($signed(sin_out));
      e = range_err;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; angle_in = '0; amp_in = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_low got=%b want=0", in_ready); end
      rst_n = 1'b1;
      #1;
      total++;
      if ({out_valid, range_err, cos_out, sin_out} !== 34'd0) begin
         bad++; $display("FAIL reset_outputs got v=%b e=%b c=%0d s=%0d want all 0", out_valid, range_err, cos_out, sin_out);
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_basic();
      int c, s, lat; logic e;
      run_op(0, 16384, c, s, e, lat);
      total++;
      if (lat != 18) begin bad++; $display("FAIL basic_latency got=%0d want=18", lat); end
      total++;
      if (c < 16380 || c > 16388) begin bad++; $display("FAIL basic_cos got=%0d want=16384+/-4", c); end
      total++;
      if (s < -4 || s > 4) begin bad++; $display("FAIL basic_sin got=%0d want=0+/-4", s); end
      total++;
      if (e !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", e); end
   endtask

   task automatic test_angles();
      int va[8] = '{900, 300, -1800, 1800, -900, 1350, -450, 450};
      int vm[8] = '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 32767};
      int vc[8] = '{0, 14189, -16384, -16384, 0, -11585, 11585, 23170};
      int vs[8] = '{16384, 8192, 0, 0, -16384, 11585, -11585, 23170};
      int c, s, lat; logic e;
      for (int k = 0; k < 8; k++) begin
         run_op(va[k], vm[k], c, s, e, lat);
         total++;
         if (lat != 18 || e !== 1'b0 || c < vc[k] - 4 || c > vc[k] + 4 || s < vs[k] - 4 || s > vs[k] + 4) begin
            bad++;
            $display("FAIL angle_%0d got c=%0d s=%0d e=%b lat=%0d want c=%0d s=%0d (+/-4) e=0 lat=18",
                     va[k], c, s, e, lat, vc[k], vs[k]);
         end
      end
   endtask

   task automatic test_full_scale();
      int c, s, lat; logic e;
      run_op(0, -32768, c, s, e, lat);
      total++;
      if (c < -32767 || c > -32763) begin bad++; $display("FAIL negfull_cos got=%0d want=-32767 (no wrap)", c); end
      total++;
      if (s < -4 || s > 4) begin bad++; $display("FAIL negfull_sin got=%0d want=0+/-4", s); end
      run_op(1234, 0, c, s, e, lat);
      total++;
      if (c != 0 || s != 0) begin bad++; $display("FAIL zero_amp got c=%0d s=%0d want 0/0", c, s); end
   endtask

   task automatic test_range();
      int va[2] = '{1801, -2000};
      int c, s, lat; logic e;
      for (int k = 0; k < 2; k++) begin
         run_op(va[k], 1000, c, s, e, lat);
         total++;
         if (lat != 18 || c != 0 || s != 0 || e !== 1'b1) begin
            bad++;
            $display("FAIL range_%0d got c=%0d s=%0d e=%b lat=%0d want 0/0 e=1 lat=18", va[k], c, s, e, lat);
         end
      end
      run_op(0, 1000, c, s, e, lat);
      total++;
      if (e !== 1'b0 || c < 996 || c > 1004) begin
         bad++; $display("FAIL range_clear got c=%0d e=%b want c=1000+/-4 e=0", c, e);
      end
   endtask

   task automatic test_stall();
      int lat;
      logic [15:0] c0, s0;
      start_op(300, 16384);
      wait_valid(lat);
      c0 = cos_out; s0 = sin_out;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || cos_out !== c0 || sin_out !== s0) begin
            bad++;
            $display("FAIL stall_%0d got v=%b rdy=%b c=%0d s=%0d want v=1 rdy=0 c=%0d s=%0d",
                     k, out_valid, in_ready, cos_out, sin_out, c0, s0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int c, s, lat; logic e; logic seen;
      start_op(900, 16384);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_discard got out_valid seen=%b want=0", seen); end
      run_op(300, 16384, c, s, e, lat);
      total++;
      if (lat != 18 || c < 14185 || c > 14193 || s < 8188 || s > 8196 || e !== 1'b0) begin
         bad++; $display("FAIL reset_mid_next got c=%0d s=%0d e=%b lat=%0d want 14189/8192 +/-4 e=0 lat=18", c, s, e, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_angles();
      test_full_scale();
      test_range();
      test_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
